wb_trace_buffer: RTL

// - Consumes the core's writeback register-write stream (reg_num/reg_data + write strobe) and

---
 rtl/wb_trace_buffer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures qualifying register writes from the core's
// writeback stage as {reg_num, reg_data, seq} records in a FIFO and drains
// them over a valid/ready port. The core is never stalled: writes that arrive
// while the FIFO is full are dropped, counted and flagged.
module wb_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int FILTER_X0 = 1,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_we,
  input  logic [4:0]                 wb_reg_num,
  input  logic [31:0]                wb_reg_data,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [4:0]                 trc_reg_num,
  output logic [31:0]                trc_reg_data,
  output logic [CNT_W-1:0]           trc_seq,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_cnt,
  input  logic                       clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [4:0]       num;
    logic [31:0]      data;
    logic [CNT_W-1:0] seq;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic qualify;
  logic is_full;
  logic is_empty;
  logic do_pop;
  logic do_push;
  logic do_drop;
  rec_t head;

  // Event qualification and push/pop/drop decisions for this cycle.
  always_comb begin
    qualify  = wb_we && !((FILTER_X0 != 0) && (wb_reg_num == 5'd0));
    is_full  = (count_q == LW'(DEPTH));
    is_empty = (count_q == '0);
    do_pop   = !is_empty && trc_ready;
    // A pop in the same cycle frees the slot the new record needs.
    do_push  = qualify && (!is_full || do_pop);
    do_drop  = qualify && is_full && !do_pop;
  end

  // Next-state for pointers, occupancy, sequence number and loss bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + LW'(do_push) - LW'(do_pop);

    // Dropped events still consume a number so the sink can see the gap.
    if (qualify) seq_d = seq_q + CNT_W'(1);

    if (do_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    // Clear has priority over a drop in the same cycle.
    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= '{num: wb_reg_num, data: wb_reg_data, seq: seq_q};
    end
  end

  // Head record is read straight from storage so a push is visible right
  // after its edge; fields are forced to zero whenever nothing is valid.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    trc_valid    = !is_empty;
    trc_reg_num  = trc_valid ? head.num  : '0;
    trc_reg_data = trc_valid ? head.data : '0;
    trc_seq      = trc_valid ? head.seq  : '0;
  end

  assign level    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
